// File: rtl/block_code_pkg.sv
// Purpose: shared types and constants for the repetition block-code decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package block_code_pkg;

  // Decoded bits per output beat.
  localparam int OUT_WIDTH = 16;

  // Accumulator width. The extra 5 bits hold a sum of up to 32 full-scale symbols.
  function automatic int acc_width(input int data_width);
    return data_width + 5;
  endfunction

  typedef enum logic {
    S_COLLECT = 1'b0,
    S_OUTPUT  = 1'b1
  } state_e;

endpackage

// File: rtl/block_code_group_acc.sv
// Purpose: signed group accumulator. It sums symbols until the count reaches L, then slices the sign.
// Latency: bit_valid_o/bit_value_o are combinational on the beat that completes a group.
// Backpressure: none; it only advances when sym_vld_i is high.
// Ports: clk, rst_n (async low); sym_vld_i/sym_dat_i accepted symbol; code_len_i is the
//        effective L for this beat; clear_i drops any partial group; bit_valid_o/bit_value_o.
module block_code_group_acc
  import block_code_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sym_vld_i,
  input  logic [DATA_WIDTH-1:0] sym_dat_i,
  input  logic [7:0]            code_len_i,
  input  logic                  clear_i,
  output logic                  bit_valid_o,
  output logic                  bit_value_o
);

  localparam int AW = acc_width(DATA_WIDTH);

  logic signed [AW-1:0] acc_q, acc_d, sum;
  logic [7:0]           cnt_q, cnt_d, cnt_inc, len_eff;

  always_comb begin
    // L=0 behaves as L=1.
    len_eff     = (code_len_i == 8'd0) ? 8'd1 : code_len_i;
    sum         = acc_q + {{(AW-DATA_WIDTH){sym_dat_i[DATA_WIDTH-1]}}, sym_dat_i};
    cnt_inc     = cnt_q + 8'd1;
    bit_valid_o = sym_vld_i && (cnt_inc == len_eff);
    // A sum of exactly zero has a clear sign bit, so it decodes to 0.
    bit_value_o = sum[AW-1];

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      // Frame end: the completed bit (if any) is already on bit_*_o; the partial group is dropped.
      acc_d = '0;
      cnt_d = '0;
    end else if (sym_vld_i) begin
      if (bit_valid_o) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/block_code_decoder.sv
// Purpose: AXI4-Stream repetition-code decoder. It turns a frame of soft symbols into one packed 16-bit beat.
// Latency: the output is valid on the cycle after the final input beat is accepted.
// Backpressure: input tready is low while the word waits; the word is held until m_axis_tready.
// Ports: clk, s_axis_aresetn (async low); code_length is latched on a frame's first beat;
//        s_axis_* soft-symbol slave; m_axis_* decoded-word master (tlast mirrors tvalid).
module block_code_decoder
  import block_code_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_SYMBOLS = 20
) (
  input  logic                  clk,
  input  logic                  s_axis_aresetn,
  input  logic [7:0]            code_length,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [OUT_WIDTH-1:0]  m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready
);

  localparam int CNT_W = 6;  // frame count holds up to 32 symbols
  localparam int BIT_W = 5;  // bit index saturates at OUT_WIDTH

  state_e               state_q, state_d;
  logic                 rdy_en_q;
  logic [CNT_W-1:0]     sym_cnt_q, sym_cnt_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [OUT_WIDTH-1:0] word_q, word_d;
  logic [7:0]           len_q, len_d;

  logic       accept, first_beat, frame_end;
  logic [7:0] len_cur;
  logic       bit_valid, bit_value;

  // rdy_en_q keeps tready low until the first edge after reset is released.
  assign s_axis_tready = rdy_en_q && (state_q == S_COLLECT);
  assign m_axis_tvalid = (state_q == S_OUTPUT);
  assign m_axis_tlast  = (state_q == S_OUTPUT);
  assign m_axis_tdata  = (state_q == S_OUTPUT) ? word_q : '0;

  assign accept     = s_axis_tvalid && s_axis_tready;
  assign first_beat = (sym_cnt_q == '0);
  // The first beat of a frame uses the live code_length. Later beats use the latched copy.
  assign len_cur    = first_beat ? code_length : len_q;
  assign frame_end  = accept &&
                      (s_axis_tlast || ((sym_cnt_q + CNT_W'(1)) == CNT_W'(NUM_SYMBOLS)));

  block_code_group_acc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_group_acc (
    .clk        (clk),
    .rst_n      (s_axis_aresetn),
    .sym_vld_i  (accept),
    .sym_dat_i  (s_axis_tdata),
    .code_len_i (len_cur),
    .clear_i    (frame_end),
    .bit_valid_o(bit_valid),
    .bit_value_o(bit_value)
  );

  always_comb begin
    state_d   = state_q;
    sym_cnt_d = sym_cnt_q;
    bit_idx_d = bit_idx_q;
    word_d    = word_q;
    len_d     = len_q;

    case (state_q)
      S_COLLECT: begin
        if (accept) begin
          sym_cnt_d = sym_cnt_q + CNT_W'(1);
          if (first_beat) begin
            len_d = code_length;
          end
          // Bits past the sixteenth are dropped. The index saturates so it never wraps.
          if (bit_valid && (bit_idx_q < BIT_W'(OUT_WIDTH))) begin
            word_d[4'd15 - bit_idx_q[3:0]] = bit_value;
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
          if (frame_end) begin
            state_d   = S_OUTPUT;
            sym_cnt_d = '0;
            bit_idx_d = '0;
          end
        end
      end
      S_OUTPUT: begin
        if (m_axis_tready) begin
          state_d = S_COLLECT;
          word_d  = '0;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q   <= S_COLLECT;
      rdy_en_q  <= 1'b0;
      sym_cnt_q <= '0;
      bit_idx_q <= '0;
      word_q    <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      rdy_en_q  <= 1'b1;
      sym_cnt_q <= sym_cnt_d;
      bit_idx_q <= bit_idx_d;
      word_q    <= word_d;
      len_q     <= len_d;
    end
  end

endmodule

// File: tb/tb_block_code_decoder.sv
// Purpose: self-checking bench for block_code_decoder against a group-sum reference model.
// Latency: checks output valid on the cycle after the final accepted beat.
// Backpressure: exercises held outputs under m_axis_tready low and input bubbles.
module tb_block_code_decoder;

  localparam int NUM = 20;

  logic        clk = 1'b0;
  logic        s_axis_aresetn;
  logic [7:0]  code_length;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [15:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  int checks   = 0;
  int failures = 0;
  int sym[32];

  always #5 clk = ~clk;

  block_code_decoder #(.DATA_WIDTH(8), .NUM_SYMBOLS(NUM)) dut (
    .clk           (clk),
    .s_axis_aresetn(s_axis_aresetn),
    .code_length   (code_length),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
    end
  endtask

  // Reference: whole groups of len symbols within the first n_end symbols; each group's sign gives one bit.
  function automatic logic [15:0] model_word(input int n_end, input int len);
    int          l;
    int          ng;
    int          s;
    logic [15:0] w;
    l  = (len == 0) ? 1 : len;
    ng = n_end / l;
    w  = '0;
    for (int g = 0; g < ng && g < 16; g++) begin
      s = 0;
      for (int k = 0; k < l; k++) s += sym[g*l + k];
      w[15-g] = (s < 0);
    end
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) sym[i] = int'($urandom_range(0, 255)) - 128;
  endtask

  task automatic send_frame(input int n, input int len, input bit use_last, input int gap);
    int waited;
    for (int i = 0; i < n; i++) begin
      s_axis_tvalid = 1'b0;
      repeat (gap) tick();
      waited = 0;
      while (!s_axis_tready && waited < 100) begin
        tick();
        waited++;
      end
      if (!s_axis_tready) begin
        chk("in_rdy_timeout", 32'(s_axis_tready), 32'd1);
        s_axis_tvalid = 1'b0;
        return;
      end
      if (i == 0) chk("vld_low_in_frame", 32'(m_axis_tvalid), 32'd0);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'(sym[i]);
      // After the first beat, code_length is scrambled. The DUT must ignore it.
      code_length   = (i == 0) ? 8'(len) : 8'($urandom);
      s_axis_tlast  = use_last && (i == n - 1);
      tick();
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    chk("latency_vld", 32'(m_axis_tvalid), 32'd1);
  endtask

  task automatic take_output(input logic [15:0] exp, input int hold);
    chk("out_vld", 32'(m_axis_tvalid), 32'd1);
    chk("out_dat", 32'(m_axis_tdata), 32'(exp));
    chk("out_last", 32'(m_axis_tlast), 32'd1);
    chk("in_rdy_during_out", 32'(s_axis_tready), 32'd0);
    if (hold > 0) begin
      m_axis_tready = 1'b0;
      for (int c = 0; c < hold; c++) begin
        tick();
        chk("hold_vld", 32'(m_axis_tvalid), 32'd1);
        chk("hold_dat", 32'(m_axis_tdata), 32'(exp));
        chk("hold_in_rdy", 32'(s_axis_tready), 32'd0);
      end
    end
    m_axis_tready = 1'b1;
    tick();
    chk("post_hs_vld", 32'(m_axis_tvalid), 32'd0);
    chk("post_hs_in_rdy", 32'(s_axis_tready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int lens[10];
    int n, len, gap, hold;
    bit use_last;
    int b;
    lens = '{0, 1, 2, 3, 4, 5, 7, 10, 20, 25};

    s_axis_aresetn = 1'b0;
    code_length    = 8'd0;
    s_axis_tdata   = 8'd0;
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
    m_axis_tready  = 1'b1;
    repeat (3) tick();
    chk("rst_in_rdy", 32'(s_axis_tready), 32'd0);
    chk("rst_vld", 32'(m_axis_tvalid), 32'd0);
    chk("rst_dat", 32'(m_axis_tdata), 32'd0);
    chk("rst_last", 32'(m_axis_tlast), 32'd0);
    s_axis_aresetn = 1'b1;
    #1;
    chk("rdy_before_edge", 32'(s_axis_tready), 32'd0);
    tick();
    chk("rdy_after_release", 32'(s_axis_tready), 32'd1);

    // L=10: +5 x10 then -3 x10.
    for (int i = 0; i < 20; i++) sym[i] = (i < 10) ? 5 : -3;
    send_frame(20, 10, 1'b1, 0);
    take_output(model_word(20, 10), 0);

    // L=5: the groups sum to -5, +5, 0 and -7. Inputs have 5-cycle bubbles.
    sym[0:4]   = '{-1, -1, -1, -1, -1};
    sym[5:9]   = '{1, 1, 1, 1, 1};
    sym[10:14] = '{2, -2, 1, -1, 0};
    sym[15:19] = '{-1, -1, -1, -2, -2};
    send_frame(20, 5, 1'b1, 5);
    take_output(model_word(20, 5), 3);

    // L=10 noisy symbols. The frame ends on the count. The word waits 20 cycles.
    for (int i = 0; i < 20; i++) begin
      b = int'($urandom_range(0, 1));
      sym[i] = (b != 0 ? -8 : 8) + int'($urandom_range(0, 24)) - 12;
    end
    send_frame(20, 10, 1'b0, 0);
    take_output(model_word(20, 10), 20);

    // Back-to-back frames: L=10, then L=5.
    fill_random();
    send_frame(20, 10, 1'b1, 0);
    take_output(model_word(20, 10), 0);
    fill_random();
    send_frame(20, 5, 1'b1, 0);
    take_output(model_word(20, 5), 0);

    // Early tlast on beat 12 with L=5.
    fill_random();
    send_frame(12, 5, 1'b1, 0);
    take_output(model_word(12, 5), 2);

    // Reset while beat 7 is presented, then a clean all-+1 frame with L=4.
    fill_random();
    code_length = 8'd4;
    for (int i = 0; i < 6; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'(sym[i]);
      tick();
    end
    s_axis_tdata   = 8'(sym[6]);
    s_axis_aresetn = 1'b0;
    #1;
    chk("abort_vld", 32'(m_axis_tvalid), 32'd0);
    chk("abort_in_rdy", 32'(s_axis_tready), 32'd0);
    s_axis_tvalid = 1'b0;
    tick();
    s_axis_aresetn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("abort_no_beat", 32'(m_axis_tvalid), 32'd0);
    end
    for (int i = 0; i < 20; i++) sym[i] = 1;
    send_frame(20, 4, 1'b1, 0);
    take_output(model_word(20, 4), 1);

    // Random frames, including L=0, L=1 (overflow past 16 bits), partial groups and L > frame.
    for (int f = 0; f < 14; f++) begin
      fill_random();
      len      = lens[$urandom_range(0, 9)];
      use_last = 1'($urandom_range(0, 1));
      n        = use_last ? int'($urandom_range(1, 20)) : NUM;
      gap      = int'($urandom_range(0, 2));
      hold     = int'($urandom_range(0, 4));
      send_frame(n, len, use_last, gap);
      take_output(model_word(n, len), hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/block_code_decoder.md
# block_code_decoder

Soft-decision repetition block-code decoder with AXI4-Stream slave input and master output. Consumes one frame of NUM_SYMBOLS signed soft symbols, splits it into consecutive groups of `code_length` symbols, sums each group and slices the sign to one hard bit. It emits the decoded bits as one packed 16-bit beat per frame. It sits between the demapper (soft-symbol source) and the downstream bit sink.

## Interface
- DATA_WIDTH, 8: width of one signed two's-complement soft symbol.
- NUM_SYMBOLS, 20: symbols per frame, 1..32.
- clk  in  1  sole clock; all logic on its rising edge.
- s_axis_aresetn  in  1  asynchronous, active-low reset, applied to the whole block.
- code_length  in  8  repetition length (symbols per decoded bit); sampled on the first accepted beat of each frame.
- s_axis_tdata  in  DATA_WIDTH  soft symbol; positive means bit 0, negative means bit 1.
- s_axis_tvalid  in  1  input beat valid.
- s_axis_tready  out  1  block can accept an input beat.
- s_axis_tlast  in  1  marks the last symbol of a frame.
- m_axis_tdata  out  16  decoded bits; decoded bit i is on bit 15-i; unused LSBs are 0.
- m_axis_tvalid  out  1  decoded word valid.
- m_axis_tlast  out  1  always 1 whenever m_axis_tvalid is 1 (one beat per frame).
- m_axis_tready  in  1  downstream accepts the word.

## Operation
- States: IDLE/COLLECT (s_axis_tready=1) and OUTPUT (s_axis_tready=0, m_axis_tvalid=1).
- On each accepted beat (tvalid and tready), sign-extend the symbol and add it into a signed accumulator of DATA_WIDTH+5 bits. Increment the in-group count and the frame symbol count.
- When the in-group count reaches the latched code_length (L):
  - decoded bit = 1 if the sum is < 0, else 0 (a sum of 0 decodes to 0);
  - shift the bit into the output word at position 15-bit_index;
  - clear the accumulator and the group count;
  - increment bit_index.
- Bits beyond 16 are discarded.
- L=0 is treated as L=1.
- The frame ends on the accepted beat where s_axis_tlast=1 or the frame count equals NUM_SYMBOLS, whichever comes first. A partial trailing group is discarded.
- At frame end, move to OUTPUT holding the word. When m_axis_tready=1 the word is taken; all counters, the accumulator and the word are cleared and the block returns to COLLECT.
- Supported configurations for NUM_SYMBOLS=20: L ∈ {2,4,5,10,20}, giving 10, 5, 4, 2 and 1 bits respectively.

## Timing
- Reset (asynchronous, active low): s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, state COLLECT, all counters and the accumulator 0.
- s_axis_tready rises on the first clock edge after reset release.
- Latency: m_axis_tvalid=1 on the cycle after the final input beat is accepted, with data complete including the last group's bit.
- Master outputs stay stable while tvalid=1 and tready=0. The word may wait for an arbitrary number of cycles.
- On the cycle of output handshake s_axis_tready stays 0. It is 1 from the next cycle.
- Input bubbles (tvalid=0) are ignored; the state is held.
- Reset asserted mid-frame or mid-output: partial state is discarded immediately and no beat is emitted.
- A code_length change mid-frame has no effect until the next frame's first beat.

## Structure
- Shared package block_code_pkg holds OUT_WIDTH=16, the accumulator width function (DATA_WIDTH+5), and the state enum (S_COLLECT, S_OUTPUT).
- One sub-module, block_code_group_acc: signed accumulate, group count against L, sign slice. Its outputs are bit_valid and bit_value.
- The top module holds the AXI handshake FSM, frame counter and output shift register.

## Test plan
- L=10, 20 beats with values +5 ×10 then −3 ×10, tlast on beat 20, tready always 1 -> one beat, tdata=0x4000, tlast=1.
- L=5, symbols group0 all −1, group1 all +1, group2 sum 0, group3 sum −7, input delay 5 cycles -> tdata=0x9000.
- L=10, random SNR −2 dB symbols, m_axis_tready toggling 20 cycles low / 10 cycles high -> data held stable and matches the reference model bits 15..14; s_axis_tready=0 until the handshake.
- Back-to-back frames, first with L=10, then L=5 changed between frames -> two correct beats; the second uses L=5.
- s_axis_tlast on beat 12 with L=5 -> frame ends early; bits from groups 0-1 only, remaining bits 0.
- Reset asserted on beat 7 of a frame, then a full new frame with all +1 and L=4 -> no output beat from the aborted frame; then tdata=0x0000, tlast=1.
